// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the memory-access stage: word type, stage FSM
// states and a word-granular address compare used by the link logic.
package cpu_types_pkg;

   localparam int WORD_W  = 32;
   localparam int WADDR_W = WORD_W - 2;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [WADDR_W-1:0] waddr_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   localparam word_t WORD_MASK = 32'hFFFF_FFFC;

   // Two byte addresses fall in the same 32-bit word.
   function automatic logic same_word(input word_t a, input word_t b);
      return ((a ^ b) & WORD_MASK) == '0;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-cache request/response bus between the memory stage (master) and the
// data cache (slave).
interface mem_access_if;
   import cpu_types_pkg::*;

   logic  dmemREN_o;
   logic  dmemWEN_o;
   word_t dmemaddr_o;
   word_t dmemstore_o;
   logic  dhit_i;
   word_t dmemload_i;

   modport master (
      output dmemREN_o,
      output dmemWEN_o,
      output dmemaddr_o,
      output dmemstore_o,
      input  dhit_i,
      input  dmemload_i
   );

   modport slave (
      input  dmemREN_o,
      input  dmemWEN_o,
      input  dmemaddr_o,
      input  dmemstore_o,
      output dhit_i,
      output dmemload_i
   );

endinterface

// File: rtl/mem_access_link_reg.sv
// Load-linked reservation: one word address plus a valid bit, broken by a
// matching own store or a matching remote snoop.
module link_reg
   import cpu_types_pkg::*;
(
   input  logic   CLK,
   input  logic   RST,
   input  logic   set,
   input  logic   store_done,
   input  word_t  addr,
   input  logic   snoop_valid,
   input  word_t  snoop_addr,
   output logic   link_valid,
   output waddr_t link_addr,
   output logic   snoop_hit
);

   logic   link_valid_reg;
   waddr_t link_addr_reg;
   logic   store_match;
   logic   snoop_on_set;

   assign store_match  = same_word(addr, {link_addr_reg, 2'b00});
   assign snoop_hit    = snoop_valid & link_valid_reg &
                         same_word(snoop_addr, {link_addr_reg, 2'b00});
   // A snoop to the word being linked this very edge kills the new link.
   assign snoop_on_set = snoop_valid & same_word(snoop_addr, addr);

   always_ff @(posedge CLK) begin
      if (RST) begin
         link_valid_reg <= 1'b0;
         link_addr_reg  <= '0;
      end else if (set) begin
         link_addr_reg  <= addr[31:2];
         link_valid_reg <= ~snoop_on_set;
      end else if ((store_done & store_match) | snoop_hit) begin
         link_valid_reg <= 1'b0;
      end
   end

   assign link_valid = link_valid_reg;
   assign link_addr  = link_addr_reg;

endmodule

// File: rtl/mem_access.sv
// Memory stage controller: issues one data-cache access at a time, stalls the
// pipeline until the cache answers, and handles LL/SC through link_reg.
module mem_access
   import cpu_types_pkg::*;
(
   input  logic   CLK,
   input  logic   RST,
   input  logic   valid_i,
   input  logic   memren_i,
   input  logic   memwen_i,
   input  logic   ll_i,
   input  logic   sc_i,
   input  word_t  addr_i,
   input  word_t  store_i,
   mem_access_if.master dmem,
   input  logic   snoop_valid_i,
   input  word_t  snoop_addr_i,
   output word_t  dload_o,
   output logic   stall_o,
   output logic   memwb_en_o
);

   mem_state_t state_reg, state_next;
   word_t      dload_reg, dload_next;

   logic   link_valid;
   waddr_t link_addr;
   logic   snoop_hit;
   logic   link_set;
   logic   store_done;
   logic   mem_op;
   logic   is_load;
   logic   sc_ok;
   logic   sc_fail;
   logic   stall;
   logic   ren;
   logic   wen;

   assign mem_op  = valid_i & (memren_i | memwen_i);
   assign is_load = memren_i & ~memwen_i;
   // A snoop landing on the linked word in the same cycle spoils the SC.
   assign sc_ok   = link_valid & same_word(addr_i, {link_addr, 2'b00}) & ~snoop_hit;
   assign sc_fail = valid_i & sc_i & ~sc_ok;

   link_reg u_link_reg (
      .CLK         (CLK),
      .RST         (RST),
      .set         (link_set),
      .store_done  (store_done),
      .addr        (addr_i),
      .snoop_valid (snoop_valid_i),
      .snoop_addr  (snoop_addr_i),
      .link_valid  (link_valid),
      .link_addr   (link_addr),
      .snoop_hit   (snoop_hit)
   );

   always_comb begin
      state_next = state_reg;
      dload_next = dload_reg;
      stall      = 1'b0;
      ren        = 1'b0;
      wen        = 1'b0;
      link_set   = 1'b0;
      store_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sc_fail) begin
               dload_next = '0;
            end else if (mem_op) begin
               stall      = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            ren = is_load;
            wen = memwen_i;
            if (dmem.dhit_i) begin
               state_next = IDLE;
               store_done = memwen_i;
               link_set   = ll_i & is_load;
               if (sc_i & memwen_i) begin
                  dload_next = 32'd1;
               end else if (is_load) begin
                  dload_next = dmem.dmemload_i;
               end
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         dload_reg <= '0;
      end else begin
         state_reg <= state_next;
         dload_reg <= dload_next;
      end
   end

   assign dmem.dmemREN_o   = ren;
   assign dmem.dmemWEN_o   = wen;
   assign dmem.dmemaddr_o  = addr_i;
   assign dmem.dmemstore_o = store_i;

   assign dload_o    = dload_reg;
   assign stall_o    = stall;
   assign memwb_en_o = ~stall;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, LL/SC with snoops and reset
// in the middle of an access, each step checked against hand-derived values.
module tb_mem_access;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  RST;
   logic  valid_i, memren_i, memwen_i, ll_i, sc_i;
   word_t addr_i, store_i;
   logic  snoop_valid_i;
   word_t snoop_addr_i;
   word_t dload_o;
   logic  stall_o, memwb_en_o;

   int vectors     = 0;
   int miscompares = 0;
   int stall_cnt   = 0;

   mem_access_if dbus ();

   mem_access dut (
      .CLK           (CLK),
      .RST           (RST),
      .valid_i       (valid_i),
      .memren_i      (memren_i),
      .memwen_i      (memwen_i),
      .ll_i          (ll_i),
      .sc_i          (sc_i),
      .addr_i        (addr_i),
      .store_i       (store_i),
      .dmem          (dbus),
      .snoop_valid_i (snoop_valid_i),
      .snoop_addr_i  (snoop_addr_i),
      .dload_o       (dload_o),
      .stall_o       (stall_o),
      .memwb_en_o    (memwb_en_o)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic instr(input logic v, input logic rn, input logic wn,
                        input logic ll, input logic sc, input word_t a, input word_t s);
      valid_i  = v;
      memren_i = rn;
      memwen_i = wn;
      ll_i     = ll;
      sc_i     = sc;
      addr_i   = a;
      store_i  = s;
   endtask

   task automatic nop();
      instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Memory op whose dhit arrives in the first ACCESS cycle.
   task automatic run_op(input string tag, input logic rn, input logic wn,
                         input logic ll, input logic sc, input word_t a,
                         input word_t s, input word_t ld,
                         input logic exp_ren, input logic exp_wen);
      tick();
      instr(1'b1, rn, wn, ll, sc, a, s);
      settle();
      chkb({tag, " idle stall"}, stall_o, 1'b1);
      tick();
      settle();
      chkb({tag, " ren"}, dbus.dmemREN_o, exp_ren);
      chkb({tag, " wen"}, dbus.dmemWEN_o, exp_wen);
      chk({tag, " addr"}, dbus.dmemaddr_o, a);
      chk({tag, " store"}, dbus.dmemstore_o, s);
      dbus.dhit_i     = 1'b1;
      dbus.dmemload_i = ld;
      settle();
      chkb({tag, " hit stall"}, stall_o, 1'b0);
      tick();
      dbus.dhit_i = 1'b0;
      nop();
      settle();
   endtask

   // SC that must fail: no stall, no write, dload cleared at next edge.
   task automatic sc_fail(input string tag, input word_t a,
                          input logic sv, input word_t sa);
      tick();
      snoop_valid_i = sv;
      snoop_addr_i  = sa;
      instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 32'h5);
      settle();
      chkb({tag, " stall"}, stall_o, 1'b0);
      chkb({tag, " wen"}, dbus.dmemWEN_o, 1'b0);
      chkb({tag, " memwb"}, memwb_en_o, 1'b1);
      tick();
      snoop_valid_i = 1'b0;
      nop();
      settle();
      chk({tag, " dload"}, dload_o, 32'h0);
   endtask

   initial begin
      RST             = 1'b1;
      snoop_valid_i   = 1'b0;
      snoop_addr_i    = 32'h0;
      dbus.dhit_i     = 1'b0;
      dbus.dmemload_i = 32'h0;
      nop();
      tick();
      tick();
      RST = 1'b0;
      settle();
      chk("rst dload", dload_o, 32'h0);
      chkb("rst ren", dbus.dmemREN_o, 1'b0);
      chkb("rst wen", dbus.dmemWEN_o, 1'b0);
      chkb("rst stall", stall_o, 1'b0);
      chkb("rst memwb", memwb_en_o, 1'b1);

      // LW 0x100, dhit on the fourth ACCESS cycle.
      tick();
      instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
      settle();
      chkb("lw idle ren", dbus.dmemREN_o, 1'b0);
      chkb("lw idle memwb", memwb_en_o, 1'b0);
      stall_cnt += int'(stall_o);
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chkb("lw wait ren", dbus.dmemREN_o, 1'b1);
         chk("lw wait addr", dbus.dmemaddr_o, 32'h100);
         chkb("lw wait memwb", memwb_en_o, 1'b0);
         stall_cnt += int'(stall_o);
      end
      tick();
      dbus.dhit_i     = 1'b1;
      dbus.dmemload_i = 32'hDEADBEEF;
      settle();
      chkb("lw hit stall", stall_o, 1'b0);
      chkb("lw hit memwb", memwb_en_o, 1'b1);
      stall_cnt += int'(stall_o);
      tick();
      dbus.dhit_i = 1'b0;
      nop();
      settle();
      chk("lw dload", dload_o, 32'hDEADBEEF);
      chk("lw stall cycles", 32'(stall_cnt), 32'd4);
      chkb("lw done ren", dbus.dmemREN_o, 1'b0);

      // Back-to-back ALU ops and a bubble carrying stray memren.
      for (int i = 0; i < 3; i++) begin
         tick();
         instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40 + 32'(i), 32'h55);
         settle();
         chkb("add stall", stall_o, 1'b0);
         chkb("add memwb", memwb_en_o, 1'b1);
         chk("add dload", dload_o, 32'hDEADBEEF);
      end
      tick();
      instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
      settle();
      chkb("bubble stall", stall_o, 1'b0);
      tick();
      nop();
      settle();
      chk("bubble dload", dload_o, 32'hDEADBEEF);

      // memren+memwen together: write only, dload untouched.
      run_op("sw rw", 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hA5A5A5A5, 32'h11111111, 1'b0, 1'b1);
      chk("sw rw dload", dload_o, 32'hDEADBEEF);

      // LL then matching SC succeeds; a second SC then fails.
      run_op("ll1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h1234, 1'b1, 1'b0);
      chk("ll1 dload", dload_o, 32'h1234);
      run_op("sc1", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h5, 32'hFFFF, 1'b0, 1'b1);
      chk("sc1 dload", dload_o, 32'h1);
      sc_fail("sc2 relink", 32'h200, 1'b0, 32'h0);

      // Snoop between LL and SC breaks the link.
      run_op("ll2", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h77, 1'b1, 1'b0);
      tick();
      snoop_valid_i = 1'b1;
      snoop_addr_i  = 32'h200;
      settle();
      sc_fail("sc snoop", 32'h200, 1'b0, 32'h0);

      // Snoop to the same word in the SC cycle itself.
      run_op("ll3", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h88, 1'b1, 1'b0);
      chk("ll3 dload", dload_o, 32'h88);
      sc_fail("sc snoop same", 32'h200, 1'b1, 32'h203);

      // Snoop to a neighbouring word leaves the link alone.
      run_op("ll4", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h99, 1'b1, 1'b0);
      snoop_valid_i = 1'b1;
      snoop_addr_i  = 32'h204;
      run_op("sc4", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h6, 32'h0, 1'b0, 1'b1);
      chk("sc4 dload", dload_o, 32'h1);

      // Snoop on the LL completion edge wins.
      snoop_addr_i = 32'h200;
      run_op("ll5", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hAB, 1'b1, 1'b0);
      snoop_valid_i = 1'b0;
      chk("ll5 dload", dload_o, 32'hAB);
      sc_fail("sc after ll snoop", 32'h200, 1'b0, 32'h0);

      // Own store to the linked word (different byte) breaks the link.
      run_op("ll6", 1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hC0, 1'b1, 1'b0);
      run_op("sw own", 1'b0, 1'b1, 1'b0, 1'b0, 32'h402, 32'h1, 32'h0, 1'b0, 1'b1);
      chk("sw own dload", dload_o, 32'hC0);
      sc_fail("sc own store", 32'h400, 1'b0, 32'h0);

      // Own store to another word keeps the link.
      run_op("ll7", 1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hC1, 1'b1, 1'b0);
      run_op("sw other", 1'b0, 1'b1, 1'b0, 1'b0, 32'h404, 32'h2, 32'h0, 1'b0, 1'b1);
      run_op("sc7", 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h7, 32'h0, 1'b0, 1'b1);
      chk("sc7 dload", dload_o, 32'h1);

      // Reset in the middle of an access, with dhit arriving on the reset edge.
      run_op("ll8", 1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 32'hD0, 1'b1, 1'b0);
      tick();
      instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
      settle();
      tick();
      settle();
      chkb("rstmid ren", dbus.dmemREN_o, 1'b1);
      tick();
      RST             = 1'b1;
      dbus.dhit_i     = 1'b1;
      dbus.dmemload_i = 32'hBAD0BAD0;
      settle();
      tick();
      RST = 1'b0;
      nop();
      settle();
      chkb("rstmid ren after", dbus.dmemREN_o, 1'b0);
      chkb("rstmid wen after", dbus.dmemWEN_o, 1'b0);
      chkb("rstmid stall", stall_o, 1'b0);
      chkb("rstmid memwb", memwb_en_o, 1'b1);
      chk("rstmid dload", dload_o, 32'h0);
      tick();
      dbus.dhit_i = 1'b0;
      settle();
      chk("rstmid dload hold", dload_o, 32'h0);
      sc_fail("sc after rst", 32'h600, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
